// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared FSM encoding, next-PC selects and timeout default for fetch_mem_unit
package fetch_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    localparam int TIMEOUT_CYCLES_DEFAULT = 16;

    // Word-aligned jump target inside the current 256 MB region.
    function automatic logic [31:0] jump_target(input logic [31:0] pc, input logic [31:0] instr);
        return {pc[31:28], instr[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_mem_unit.sv
// rtl/fetch_mem_unit.sv - PC/IR/MDR datapath with a stalling IDLE/BUSY memory bus port; BUS_TIMEOUT_EN adds a sticky bus timeout
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = fetch_pkg::TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcwrite,
    input  logic        branch,
    input  logic        zero,
    input  logic        irwrite,
    input  logic        iord,
    input  logic        memwrite,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] aluresult,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] data,
    output logic [5:0]  op,
    output logic        stall,
    output logic        bus_err
);
    import fetch_pkg::*;

    logic [0:0]  state;
    logic        lat_ir;
    logic        access_req;
    logic [31:0] access_addr;
    logic [31:0] pcnext;
    logic        pc_en;
    logic        timeout_hit;

    assign access_req  = irwrite | iord;
    assign access_addr = iord ? aluout : pc;
    assign op          = instr[31:26];

`ifdef BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] busy_cnt;

    // busy_cnt holds the number of BUSY cycles already spent on this access.
    assign timeout_hit = (state == ST_BUSY) && !mem_ready
                         && (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE || mem_ready || timeout_hit)
                busy_cnt <= '0;
            else
                busy_cnt <= busy_cnt + 1'b1;
            if (timeout_hit)
                bus_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
    assign bus_err        = 1'b0;
`endif

    assign stall = ((state == ST_IDLE) && access_req)
                 | ((state == ST_BUSY) && !mem_ready && !timeout_hit);

    always_comb begin
        pcnext = pc;
        case (pcsrc)
            PC_ALU:    pcnext = aluresult;
            PC_ALUOUT: pcnext = aluout;
            PC_JUMP:   pcnext = jump_target(pc, instr);
            PC_HOLD:   pcnext = pc;
            default:   pcnext = pc;
        endcase
    end

    assign pc_en = (pcwrite | (branch & zero)) & !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            instr     <= '0;
            data      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_ir    <= 1'b0;
        end else begin
            if (pc_en)
                pc <= pcnext;

            if (state == ST_IDLE) begin
                if (access_req) begin
                    state     <= ST_BUSY;
                    mem_req   <= 1'b1;
                    mem_we    <= memwrite;
                    mem_addr  <= access_addr;
                    mem_wdata <= writedata;
                    lat_ir    <= irwrite;
                end
            end else begin
                if (mem_ready) begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    // Instruction fetch wins over a data access; stores capture nothing.
                    if (lat_ir)
                        instr <= mem_rdata;
                    else if (!mem_we)
                        data <= mem_rdata;
                end else if (timeout_hit) begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_mem_unit.sv
// tb/tb_fetch_mem_unit.sv - directed and randomized checks of fetch_mem_unit against a transaction-level model
module tb_fetch_mem_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int          TO  = 16;

    logic        clk = 1'b0;
    logic        reset, pcwrite, branch, zero, irwrite, iord, memwrite, mem_ready;
    logic [1:0]  pcsrc;
    logic [31:0] aluresult, aluout, writedata, mem_rdata;
    logic        mem_req, mem_we, stall, bus_err;
    logic [31:0] mem_addr, mem_wdata, pc, instr, data;
    logic [5:0]  op;

    always #5 clk = ~clk;

    fetch_mem_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .pcwrite(pcwrite), .branch(branch), .zero(zero),
        .irwrite(irwrite), .iord(iord), .memwrite(memwrite), .pcsrc(pcsrc),
        .aluresult(aluresult), .aluout(aluout), .writedata(writedata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .instr(instr),
        .data(data), .op(op), .stall(stall), .bus_err(bus_err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        ir;
    } acc_t;

    logic [31:0] m_pc, m_instr, m_data;
    logic        m_err;
    int          m_busy_cycles;
    acc_t        pend[$];

    task automatic model_reset();
        m_pc = RPC;
        m_instr = '0;
        m_data = '0;
        m_err = 1'b0;
        m_busy_cycles = 0;
        pend.delete();
    endtask

    // One clock: check outputs against the model, advance the model, end at the next negedge.
    task automatic step();
        logic        exp_stall, do_abort, busy;
        logic [31:0] n_pc;
        acc_t        a;
        #1;
        if (reset) begin
            @(posedge clk);
            model_reset();
            @(negedge clk);
            return;
        end
        busy = (pend.size() != 0);
        do_abort = 1'b0;
`ifdef BUS_TIMEOUT_EN
        do_abort = busy && !mem_ready && (m_busy_cycles == TO - 1);
`endif
        exp_stall = busy ? (!mem_ready && !do_abort) : (irwrite | iord);
        check("stall", stall, exp_stall);
        check("mem_req", mem_req, busy);
        if (busy) begin
            check("mem_addr", mem_addr, pend[0].addr);
            check("mem_we", mem_we, pend[0].we);
            check("mem_wdata", mem_wdata, pend[0].wdata);
        end
        check("pc", pc, m_pc);
        check("instr", instr, m_instr);
        check("data", data, m_data);
        check("op", op, m_instr[31:26]);
        check("bus_err", bus_err, m_err);

        n_pc = m_pc;
        if ((pcwrite | (branch & zero)) && !exp_stall) begin
            case (pcsrc)
                2'd0: n_pc = aluresult;
                2'd1: n_pc = aluout;
                2'd2: n_pc = {m_pc[31:28], m_instr[25:0], 2'b00};
                default: n_pc = m_pc;
            endcase
        end
        if (busy) begin
            if (mem_ready) begin
                if (pend[0].ir) m_instr = mem_rdata;
                else if (!pend[0].we) m_data = mem_rdata;
                void'(pend.pop_front());
                m_busy_cycles = 0;
            end else if (do_abort) begin
                void'(pend.pop_front());
                m_busy_cycles = 0;
                m_err = 1'b1;
            end else begin
                m_busy_cycles++;
            end
        end else if (irwrite | iord) begin
            a.addr = iord ? aluout : m_pc;
            a.wdata = writedata;
            a.we = memwrite;
            a.ir = irwrite;
            pend.push_back(a);
        end
        @(posedge clk);
        m_pc = n_pc;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        pcwrite = 0; branch = 0; zero = 0; irwrite = 0; iord = 0; memwrite = 0;
        mem_ready = 0; pcsrc = 2'd0; aluresult = '0; aluout = '0; writedata = '0; mem_rdata = '0;
    endtask

    initial begin
        int nstall;
        clear_inputs();
        reset = 1;
        model_reset();
        @(negedge clk);
        step();
        step();
        reset = 0;
        check("rst_pc", pc, RPC);
        check("rst_instr", instr, 32'h0);
        check("rst_data", data, 32'h0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_bus_err", bus_err, 1'b0);

        // Instruction fetch with zero wait states.
        irwrite = 1; pcwrite = 1; pcsrc = 2'd0; aluresult = 32'd4;
        #1 check("fetch_first_stall", stall, 1'b1);
        step();
        mem_ready = 1; mem_rdata = 32'h8C08_0004;
        #1 check("fetch_addr", mem_addr, 32'h0);
        check("fetch_ready_stall", stall, 1'b0);
        step();
        clear_inputs();
        check("fetch_instr", instr, 32'h8C08_0004);
        check("fetch_op", op, 6'b100011);
        check("fetch_pc", pc, 32'd4);

        // Fetch with three wait states.
        irwrite = 1; pcwrite = 1; aluresult = 32'd8; mem_rdata = 32'h0800_0010;
        nstall = 0;
        for (int k = 0; k < 5; k++) begin
            mem_ready = (k == 4);
            #1;
            if (stall) nstall++;
            if (k < 4) check("wait_pc_hold", pc, 32'd4);
            step();
        end
        clear_inputs();
        check("wait_stall_cycles", nstall, 4);
        check("wait_pc", pc, 32'd8);

        // Store.
        iord = 1; memwrite = 1; aluout = 32'h40; writedata = 32'hDEAD_BEEF;
        step();
        mem_ready = 1; mem_rdata = 32'h1234_5678;
        #1 check("store_we", mem_we, 1'b1);
        check("store_addr", mem_addr, 32'h40);
        check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        clear_inputs();
        check("store_instr", instr, 32'h0800_0010);
        check("store_data", data, 32'h0);

        // Jump, then branch not taken / taken.
        pcsrc = 2'd2; pcwrite = 1;
        step();
        check("jump_pc", pc, 32'h40);
        pcwrite = 0; pcsrc = 2'd0; branch = 1; zero = 0; aluresult = 32'h100;
        step();
        check("branch_nt_pc", pc, 32'h40);
        zero = 1;
        step();
        check("branch_t_pc", pc, 32'h100);
        clear_inputs();

        // Reset during BUSY abandons the read.
        iord = 1; aluout = 32'h80;
        step();
        iord = 0;
        step();
        reset = 1; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        step();
        reset = 0; mem_ready = 0;
        #1 check("rstbusy_mem_req", mem_req, 1'b0);
        check("rstbusy_pc", pc, RPC);
        check("rstbusy_data", data, 32'h0);

`ifdef BUS_TIMEOUT_EN
        iord = 1; aluout = 32'h10;
        step();
        iord = 0;
        for (int k = 0; k < TO - 1; k++) step();
        #1 check("to_stall", stall, 1'b0);
        step();
        check("to_bus_err", bus_err, 1'b1);
        check("to_mem_req", mem_req, 1'b0);
        for (int k = 0; k < 3; k++) step();
        check("to_err_held", bus_err, 1'b1);
        reset = 1;
        step();
        reset = 0;
        check("to_err_cleared", bus_err, 1'b0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            irwrite   = ($urandom_range(0, 3) == 0);
            iord      = !irwrite && ($urandom_range(0, 3) == 0);
            memwrite  = iord && $urandom_range(0, 1);
            pcwrite   = ($urandom_range(0, 2) == 0);
            branch    = $urandom_range(0, 1);
            zero      = $urandom_range(0, 1);
            pcsrc     = 2'($urandom_range(0, 3));
            aluresult = $urandom;
            aluout    = $urandom;
            writedata = $urandom;
            mem_rdata = $urandom;
            mem_ready = ($urandom_range(0, 4) < 2);
            step();
        end
        reset = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_mem_unit.md
FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: BUSY cycles before abort (used only with BUS_TIMEOUT_EN).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports pcwrite, branch, zero, irwrite, iord, memwrite  in  1 each  controller strobes and ALU zero flag.
REQ-006 SHALL have port pcsrc  in  2  next-PC select.
REQ-007 SHALL have ports aluresult, aluout, writedata  in  32 each  ALU result, ALU output register, store data.
REQ-008 SHALL have ports mem_req, mem_we  out  1 each  bus request and write enable.
REQ-009 SHALL have ports mem_addr, mem_wdata  out  32 each  bus address and write data.
REQ-010 SHALL have ports mem_rdata  in  32 and mem_ready  in  1  read data and completion.
REQ-011 SHALL have ports pc, instr, data  out  32 each  PC, instruction register, memory data register.
REQ-012 SHALL have port op  out  6  instr[31:26], feeding the main decoder.
REQ-013 SHALL have port stall  out  1  freezes controller state register when high.
REQ-014 SHALL have port bus_err  out  1  sticky timeout flag.

Function
REQ-015 SHALL define access_req = irwrite | iord; access address = iord ? aluout : pc; access write = memwrite.
REQ-016 SHALL use two-state FSM IDLE/BUSY; IDLE with access_req -> BUSY next cycle; BUSY with mem_ready=1 -> IDLE next cycle; otherwise hold.
REQ-017 SHALL register mem_req, mem_we, mem_addr, mem_wdata on the IDLE->BUSY transition; mem_req=1 exactly while in BUSY; bus outputs constant throughout BUSY.
REQ-018 SHALL drive stall combinationally = (IDLE & access_req) | (BUSY & !mem_ready).
REQ-019 SHALL ignore mem_ready while in IDLE.
REQ-020 SHALL, in the BUSY cycle with mem_ready=1, load instr <= mem_rdata if the latched access was irwrite, else load data <= mem_rdata if it was a read; writes update neither.
REQ-021 SHALL compute pcnext: pcsrc 00 aluresult, 01 aluout, 10 {pc[31:28], instr[25:0], 2'b00}, 11 pc.
REQ-022 SHALL update pc <= pcnext when (pcwrite | (branch & zero)) & !stall; otherwise hold.
REQ-023 SHALL give a minimum access latency of 2 cycles: request cycle plus one BUSY cycle with mem_ready=1.
REQ-024 SHALL, when mem_ready and a new access_req coincide, return to IDLE first; the new access starts one cycle later.

Reset
REQ-025 SHALL on reset set pc=RESET_PC, instr=0, data=0, FSM=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, bus_err=0.
REQ-026 SHALL, when reset is asserted in BUSY, abandon the access: mem_req=0 next cycle, no register capture.
REQ-027 SHALL drive stall=1 in the first post-reset cycle whenever the controller presents access_req.

Configuration
REQ-028 SHALL, with BUS_TIMEOUT_EN defined, count BUSY cycles; at TIMEOUT_CYCLES without mem_ready: set bus_err=1 (held until reset), drive stall=0 that cycle, return to IDLE, leave instr/data unchanged.
REQ-029 SHALL, without BUS_TIMEOUT_EN, omit the counter, tie bus_err=0, and wait indefinitely in BUSY.

Structure
REQ-030 SHALL place FSM state encoding, pcsrc constants (PC_ALU, PC_ALUOUT, PC_JUMP, PC_HOLD) and the TIMEOUT_CYCLES default in shared package fetch_pkg.
REQ-031 SHALL be a single module; no sub-module.

Verification
REQ-032 SHALL cover fetch: reset, irwrite=1, pcwrite=1, aluresult=4, mem_ready on 1st BUSY cycle, mem_rdata=32'h8C08_0004 -> mem_addr=0, instr=32'h8C08_0004, op=6'b100011, pc=4 after 2 cycles.
REQ-033 SHALL cover wait states: mem_ready delayed 3 BUSY cycles -> stall high 4 cycles, pc unchanged until the ready cycle.
REQ-034 SHALL cover store: iord=1, memwrite=1, aluout=32'h40, writedata=32'hDEAD_BEEF -> mem_we=1, mem_addr=32'h40, mem_wdata=32'hDEAD_BEEF; instr and data unchanged.
REQ-035 SHALL cover jump and branch: instr=32'h0800_0010, pcsrc=10, pcwrite=1 -> pc=32'h40; branch=1, zero=0 -> pc holds.
REQ-036 SHALL cover reset mid-BUSY -> mem_req=0 next cycle, pc=RESET_PC, data unchanged from reset value 0.
REQ-037 SHALL cover, with BUS_TIMEOUT_EN, mem_ready never asserted -> bus_err=1 after 16 BUSY cycles, FSM IDLE, bus_err held until reset.
